// File: rtl/jtag_scan_ctrl.sv
// TCK-domain TAP scan sequencer: turns reset / IR-scan / DR-scan commands into
// registered TMS/TDI bit streams and gathers the shifted-out TDO bits into a response.
module jtag_scan_ctrl #(
  parameter int IR_LENGTH   = 4,
  parameter int DATA_LENGTH = 29,
  parameter int LEN_W       = $clog2(DATA_LENGTH+1)
) (
  input  logic                   tck_pad_i,
  input  logic                   trst_pad_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic [1:0]             cmd_type_i,
  input  logic [IR_LENGTH-1:0]   cmd_ir_i,
  input  logic [DATA_LENGTH-1:0] cmd_dr_i,
  input  logic [LEN_W-1:0]       cmd_len_i,
  output logic                   rsp_valid_o,
  output logic [DATA_LENGTH-1:0] rsp_data_o,
  output logic                   tms_pad_o,
  output logic                   tdi_pad_o,
  input  logic                   tdo_pad_i,
  output logic                   busy_o
);

  localparam int CNT_W = (LEN_W > 3) ? LEN_W : 3;

  typedef enum logic [3:0] {
    TLR_SEQ, RTI_WAIT, IDLE, SEL_DR, SEL_IR, CAPTURE, SHIFT, EXIT1, UPDATE
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, last_q, last_d, len_last;
  logic                   is_ir_q, is_ir_d, pend_q, pend_d;
  logic [DATA_LENGTH-1:0] data_q, data_d, cap_q, cap_d, rsp_data_q, rsp_data_d;
  logic                   tms_q, tms_d, tdi_q, tdi_d, ready_q, ready_d;
  logic                   rsp_valid_q, rsp_valid_d;
  logic                   accept;

  assign accept = cmd_valid_i && ready_q;

  // Out-of-range or zero lengths fall back to a full-width scan.
  assign len_last = (cmd_len_i == '0 || cmd_len_i > LEN_W'(DATA_LENGTH))
                    ? CNT_W'(DATA_LENGTH-1) : CNT_W'(cmd_len_i - LEN_W'(1));

  always_ff @(posedge tck_pad_i or negedge trst_pad_i) begin
    if (!trst_pad_i) begin
      state_q     <= TLR_SEQ;
      cnt_q       <= '0;
      last_q      <= '0;
      is_ir_q     <= 1'b0;
      pend_q      <= 1'b0;
      data_q      <= '0;
      cap_q       <= '0;
      rsp_data_q  <= '0;
      rsp_valid_q <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      is_ir_q     <= is_ir_d;
      pend_q      <= pend_d;
      data_q      <= data_d;
      cap_q       <= cap_d;
      rsp_data_q  <= rsp_data_d;
      rsp_valid_q <= rsp_valid_d;
      tms_q       <= tms_d;
      tdi_q       <= tdi_d;
      ready_q     <= ready_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    is_ir_d = is_ir_q;
    pend_d  = pend_q;
    data_d  = data_q;
    cap_d   = cap_q;
    case (state_q)
      TLR_SEQ: begin
        if (cnt_q == CNT_W'(4)) begin
          state_d = RTI_WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RTI_WAIT: begin
        state_d = IDLE;
        pend_d  = 1'b0;
      end
      IDLE: begin
        if (accept) begin
          pend_d = 1'b1;
          cnt_d  = '0;
          cap_d  = '0;
          case (cmd_type_i)
            2'b01: begin
              state_d                = SEL_DR;
              is_ir_d                = 1'b1;
              data_d                 = '0;
              data_d[IR_LENGTH-1:0]  = cmd_ir_i;
              last_d                 = CNT_W'(IR_LENGTH-1);
            end
            2'b10: begin
              state_d = SEL_DR;
              is_ir_d = 1'b0;
              data_d  = cmd_dr_i;
              last_d  = len_last;
            end
            default: begin
              state_d = TLR_SEQ;
              is_ir_d = 1'b0;
            end
          endcase
        end
      end
      SEL_DR:  state_d = is_ir_q ? SEL_IR : CAPTURE;
      SEL_IR:  state_d = CAPTURE;
      // Two TMS=0 cycles: the first enters Capture, the second enters Shift.
      CAPTURE: begin
        if (cnt_q[0]) begin
          state_d = SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d = CNT_W'(1);
        end
      end
      SHIFT: begin
        cap_d[cnt_q] = tdo_pad_i;
        if (cnt_q == last_q) begin
          state_d = EXIT1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      EXIT1:   state_d = UPDATE;
      UPDATE: begin
        state_d = IDLE;
        pend_d  = 1'b0;
      end
      default: begin
        state_d = TLR_SEQ;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pads change right at the edge.
  always_comb begin
    tms_d       = 1'b0;
    tdi_d       = 1'b0;
    ready_d     = (state_d == IDLE);
    rsp_valid_d = 1'b0;
    rsp_data_d  = rsp_data_q;
    case (state_d)
      TLR_SEQ, SEL_DR, SEL_IR, EXIT1: tms_d = 1'b1;
      SHIFT: begin
        tms_d = (cnt_d == last_d);
        tdi_d = data_d[cnt_d];
      end
      default: tms_d = 1'b0;
    endcase
    if (pend_q && (state_q == UPDATE || state_q == RTI_WAIT)) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = (state_q == UPDATE) ? cap_q : '0;
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = ~ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign tms_pad_o   = tms_q;
  assign tdi_pad_o   = tdi_q;

endmodule

// File: tb/tb_jtag_scan_ctrl.sv
// Bench for jtag_scan_ctrl: a 1149.1 TAP model on the pads, a queue-based
// per-cycle model of the expected TMS/TDI streams, table vectors and random commands.
module tb_jtag_scan_ctrl;

  logic        tck = 1'b0;
  logic        trst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_type = '0;
  logic [3:0]  cmd_ir = '0;
  logic [28:0] cmd_dr = '0;
  logic [4:0]  cmd_len = '0;
  logic        rsp_valid;
  logic [28:0] rsp_data;
  logic        tms, tdi, busy;
  logic        tdo = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 tck = ~tck;

  jtag_scan_ctrl dut (
    .tck_pad_i   (tck),
    .trst_pad_i  (trst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_type_i  (cmd_type),
    .cmd_ir_i    (cmd_ir),
    .cmd_dr_i    (cmd_dr),
    .cmd_len_i   (cmd_len),
    .rsp_valid_o (rsp_valid),
    .rsp_data_o  (rsp_data),
    .tms_pad_o   (tms),
    .tdi_pad_o   (tdi),
    .tdo_pad_i   (tdo),
    .busy_o      (busy)
  );

  // ---------------- TAP model ----------------
  typedef enum int {
    T_TLR, T_RTI, T_SELDR, T_CAPDR, T_SHDR, T_EX1DR, T_PADR, T_EX2DR, T_UPDR,
    T_SELIR, T_CAPIR, T_SHIR, T_EX1IR, T_PAIR, T_EX2IR, T_UPIR
  } tap_e;

  tap_e       tap_st;
  logic [3:0] tap_ir, tap_ir_sr;

  function automatic tap_e tap_next(tap_e s, logic t);
    case (s)
      T_TLR:           return t ? T_TLR   : T_RTI;
      T_RTI:           return t ? T_SELDR : T_RTI;
      T_SELDR:         return t ? T_SELIR : T_CAPDR;
      T_CAPDR, T_SHDR: return t ? T_EX1DR : T_SHDR;
      T_EX1DR:         return t ? T_UPDR  : T_PADR;
      T_PADR:          return t ? T_EX2DR : T_PADR;
      T_EX2DR:         return t ? T_UPDR  : T_SHDR;
      T_UPDR, T_UPIR:  return t ? T_SELDR : T_RTI;
      T_SELIR:         return t ? T_TLR   : T_CAPIR;
      T_CAPIR, T_SHIR: return t ? T_EX1IR : T_SHIR;
      T_EX1IR:         return t ? T_UPIR  : T_PAIR;
      T_PAIR:          return t ? T_EX2IR : T_PAIR;
      T_EX2IR:         return t ? T_UPIR  : T_SHIR;
      default:         return T_TLR;
    endcase
  endfunction

  always @(posedge tck or negedge trst) begin
    if (!trst) begin
      tap_st    <= T_TLR;
      tap_ir    <= 4'b1111;
      tap_ir_sr <= 4'b0000;
    end else begin
      if (tap_st == T_CAPIR) tap_ir_sr <= 4'b0001;
      if (tap_st == T_SHIR)  tap_ir_sr <= {tdi, tap_ir_sr[3:1]};
      if (tap_st == T_UPIR)  tap_ir    <= tap_ir_sr;
      tap_st <= tap_next(tap_st, tms);
    end
  end

  // TDO changes on the falling edge: IR shifts return the capture pattern,
  // everything else is a straight loopback of TDI.
  always @(negedge tck) tdo <= (tap_st == T_SHIR) ? tap_ir_sr[0] : tdi;

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit          exp_tms_q[$];
  bit          exp_tdi_q[$];
  logic [28:0] exp_rsp;

  task automatic push(input bit t, input bit d);
    exp_tms_q.push_back(t);
    exp_tdi_q.push_back(d);
  endtask

  task automatic model_cmd(input logic [1:0] typ, input logic [3:0] ir,
                           input logic [28:0] dr, input logic [4:0] len);
    int          n;
    logic [63:0] data;
    exp_tms_q.delete();
    exp_tdi_q.delete();
    if (typ == 2'b00 || typ == 2'b11) begin
      repeat (5) push(1'b1, 1'b0);
      push(1'b0, 1'b0);
      exp_rsp = '0;
      return;
    end
    if (typ == 2'b01) begin
      n = 4;
      data = {60'd0, ir};
      exp_rsp = 29'd1;
      push(1'b1, 1'b0);
      push(1'b1, 1'b0);
    end else begin
      n = (len == 0 || len > 29) ? 29 : int'(len);
      data = {35'd0, dr};
      exp_rsp = 29'(data & ((64'd1 << n) - 64'd1));
      push(1'b1, 1'b0);
    end
    push(1'b0, 1'b0);
    push(1'b0, 1'b0);
    for (int k = 0; k < n; k++) push(k == n-1, data[k]);
    push(1'b1, 1'b0);
    push(1'b0, 1'b0);
  endtask

  // ---------------- command driver / per-cycle checker ----------------
  task automatic run_cmd(input logic [1:0] typ, input logic [3:0] ir, input logic [28:0] dr,
                         input logic [4:0] len, input bit hold, input bit noise,
                         output int lat, output int waited);
    int L;
    model_cmd(typ, ir, dr, len);
    L = exp_tms_q.size();
    cmd_type = typ; cmd_ir = ir; cmd_dr = dr; cmd_len = len; cmd_valid = 1'b1;
    waited = 0;
    lat = -1;
    while (!cmd_ready && waited < 50) begin
      @(negedge tck);
      waited++;
    end
    if (!cmd_ready) begin
      chk("accept timeout", 64'd0, 64'd1);
      cmd_valid = 1'b0;
      return;
    end
    @(negedge tck);
    if (!hold) cmd_valid = 1'b0;
    chk("busy after accept", busy, 1);
    for (int i = 0; i <= L + 4; i++) begin
      if (rsp_valid) begin
        lat = i;
        break;
      end
      if (i < L) begin
        chk($sformatf("tms[%0d]", i), tms, exp_tms_q[i]);
        chk($sformatf("tdi[%0d]", i), tdi, exp_tdi_q[i]);
      end
      if (noise && i < L) begin
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_type  = 2'($urandom);
        cmd_ir    = 4'($urandom);
        cmd_dr    = 29'($urandom);
        cmd_len   = 5'($urandom);
      end
      @(negedge tck);
    end
    if (!hold) cmd_valid = 1'b0;
    chk("latency", 64'(lat), 64'(L));
    chk("rsp_data", rsp_data, exp_rsp);
    chk("ready with rsp", cmd_ready, 1);
    chk("tap in RTI", tap_st == T_RTI, 1);
  endtask

  task automatic power_on();
    trst = 1'b0;
    #1;
    chk("rst tms", tms, 1);
    chk("rst tdi", tdi, 0);
    chk("rst ready", cmd_ready, 0);
    chk("rst busy", busy, 1);
    chk("rst rsp_valid", rsp_valid, 0);
    chk("rst rsp_data", rsp_data, 0);
    repeat (2) @(negedge tck);
    trst = 1'b1;
    chk("tms before e1", tms, 1);
    for (int e = 1; e <= 6; e++) begin
      @(negedge tck);
      chk($sformatf("po tms e%0d", e), tms, (e <= 4));
      chk($sformatf("po ready e%0d", e), cmd_ready, (e == 6));
      chk($sformatf("po rsp_valid e%0d", e), rsp_valid, 0);
    end
    chk("po tap RTI", tap_st == T_RTI, 1);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  typ;
    logic [3:0]  ir;
    logic [28:0] dr;
    logic [4:0]  len;
    logic [28:0] exp_rsp;
    int          exp_lat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int          lat, waited;
    logic [1:0]  r_typ;
    logic [3:0]  r_ir;
    logic [28:0] r_dr;
    logic [4:0]  r_len;

    tbl[0] = '{2'b00, 4'h0, 29'h0,          5'd0,  29'h0,          6};
    tbl[1] = '{2'b01, 4'h2, 29'h0,          5'd0,  29'h1,          10};
    tbl[2] = '{2'b10, 4'h0, 29'h0ABCDEF,    5'd29, 29'h0ABCDEF,    34};
    tbl[3] = '{2'b10, 4'h0, 29'h1FFFFFFF,   5'd1,  29'h1,          6};
    tbl[4] = '{2'b10, 4'h0, 29'h15555555,   5'd0,  29'h15555555,   34};
    tbl[5] = '{2'b11, 4'h0, 29'h1234567,    5'd3,  29'h0,          6};
    tbl[6] = '{2'b10, 4'h0, 29'h1234567,    5'd31, 29'h1234567,    34};
    tbl[7] = '{2'b10, 4'h0, 29'h1FFFFFA5,   5'd8,  29'h0A5,        13};

    @(negedge tck);
    power_on();

    for (int i = 0; i < 8; i++) begin
      run_cmd(tbl[i].typ, tbl[i].ir, tbl[i].dr, tbl[i].len, 1'b0, 1'b0, lat, waited);
      chk($sformatf("vec%0d latency", i), 64'(lat), 64'(tbl[i].exp_lat));
      chk($sformatf("vec%0d rsp", i), rsp_data, tbl[i].exp_rsp);
      if (tbl[i].typ == 2'b01) chk($sformatf("vec%0d tap ir", i), tap_ir, tbl[i].ir);
      repeat (2) @(negedge tck);
    end

    // Back-to-back with cmd_valid held: the second command must be taken on the rsp cycle.
    run_cmd(2'b01, 4'b1000, 29'h0, 5'd0, 1'b1, 1'b0, lat, waited);
    chk("b2b ir tap ir", tap_ir, 4'b1000);
    run_cmd(2'b10, 4'h0, 29'h0000ABC, 5'd12, 1'b0, 1'b0, lat, waited);
    chk("b2b no gap", 64'(waited), 64'd0);

    // Random commands with garbage requests sprayed while busy.
    for (int r = 0; r < 30; r++) begin
      r_typ = 2'($urandom_range(0, 3));
      r_ir  = 4'($urandom);
      r_dr  = 29'($urandom);
      r_len = 5'($urandom_range(0, 31));
      run_cmd(r_typ, r_ir, r_dr, r_len, 1'b0, 1'b1, lat, waited);
      if (r_typ == 2'b01) chk("rand tap ir", tap_ir, r_ir);
      repeat ($urandom_range(0, 2)) @(negedge tck);
    end

    // Make sure a non-zero response is held before the mid-scan reset.
    run_cmd(2'b10, 4'h0, 29'h1F0F0F0F, 5'd29, 1'b0, 1'b0, lat, waited);
    chk("pre-reset rsp held", rsp_data, 29'h1F0F0F0F);

    // Reset while shifting bit 10 of a 20-bit DR scan.
    cmd_type = 2'b10; cmd_dr = 29'h0000_0400; cmd_len = 5'd20; cmd_valid = 1'b1;
    chk("mid ready before", cmd_ready, 1);
    @(negedge tck);
    cmd_valid = 1'b0;
    repeat (13) @(negedge tck);
    chk("mid shift tms", tms, 0);
    chk("mid shift tdi bit10", tdi, 1);
    power_on();

    run_cmd(2'b10, 4'h0, 29'h0000_0155, 5'd9, 1'b0, 1'b0, lat, waited);
    chk("post-reset rsp", rsp_data, 29'h0000_0155);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
